// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state encoding and default operand width for the divider.
package seq_divider_pkg;
    localparam int DEFAULT_WIDTH = 4;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring-division step (shift in a dividend bit, trial subtract, select).
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    // Partial remainder stays below the divisor, so the top bit of the difference is the borrow.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    // quo_q starts as the dividend and shifts quotient bits in as dividend bits shift out.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_bit (quo_q[WIDTH-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (in_valid) begin
                dsr_d   = divisor;
                cnt_d   = '0;
                dbz_d   = (divisor == '0);
                state_d = (divisor == '0) ? DONE : CALC;
                quo_d   = (divisor == '0) ? '1 : dividend;
                rem_d   = (divisor == '0) ? dividend : '0;
            end
            CALC: begin
                quo_d   = {quo_q[WIDTH-2:0], step_q};
                rem_d   = step_rem;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == LAST) ? DONE : CALC;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule
